// File: rtl/burst_tx.sv
// burst_tx: emits a fixed-length square-wave carrier burst stepped by an external tick.
// Define BURST_TX_GAP_EN to hold the block busy for GAP_TICKS ticks after each burst.
module burst_tx #(
  parameter int unsigned PULSES_PER_BURST = 8,
  parameter int unsigned GAP_TICKS        = 4
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                tick_in,
  input  logic                                start_in,
  input  logic                                abort_in,
  output logic                                sig_out,
  output logic                                busy_out,
  output logic                                done_out,
  output logic [$clog2(PULSES_PER_BURST)-1:0] pulse_idx_out
);

  localparam int unsigned IDX_W = $clog2(PULSES_PER_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PULSES_PER_BURST - 1);

`ifdef BURST_TX_GAP_EN
  localparam int unsigned GAP_W = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_HIGH, S_LOW, S_GAP} state_t;

  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

  // The guard interval is compiled out, so its length has no consumer.
  logic unused_gap_ticks;
  assign unused_gap_ticks = ^GAP_TICKS;
`endif

  state_t           state_q;
  state_t           state_d;
  logic             sig_d;
  logic             done_d;
  logic [IDX_W-1:0] idx_d;

  // Next-state and next-output logic; abort outranks every tick-driven move.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_out;
    done_d  = 1'b0;
    idx_d   = pulse_idx_out;
`ifdef BURST_TX_GAP_EN
    gap_d   = gap_q;
`endif
    if (abort_in && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      sig_d   = 1'b0;
      idx_d   = '0;
`ifdef BURST_TX_GAP_EN
      gap_d   = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_in && !abort_in) begin
            state_d = S_ARM;
          end
        end
        S_ARM: begin
          if (tick_in) begin
            state_d = S_HIGH;
            sig_d   = 1'b1;
          end
        end
        S_HIGH: begin
          if (tick_in) begin
            state_d = S_LOW;
            sig_d   = 1'b0;
          end
        end
        S_LOW: begin
          if (tick_in) begin
            if (pulse_idx_out < LAST_IDX) begin
              state_d = S_HIGH;
              sig_d   = 1'b1;
              idx_d   = pulse_idx_out + IDX_W'(1);
            end else begin
              done_d  = 1'b1;
              idx_d   = '0;
              state_d = S_IDLE;
`ifdef BURST_TX_GAP_EN
              if (GAP_TICKS != 0) begin
                state_d = S_GAP;
              end
`endif
            end
          end
        end
`ifdef BURST_TX_GAP_EN
        S_GAP: begin
          if (tick_in) begin
            if ((32'(gap_q) + 32'd1) >= GAP_TICKS) begin
              gap_d   = '0;
              state_d = S_IDLE;
            end else begin
              gap_d = gap_q + GAP_W'(1);
            end
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
          sig_d   = 1'b0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // State and registered outputs; busy mirrors the state being entered.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= S_IDLE;
      sig_out       <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      pulse_idx_out <= '0;
`ifdef BURST_TX_GAP_EN
      gap_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sig_out       <= sig_d;
      busy_out      <= (state_d != S_IDLE);
      done_out      <= done_d;
      pulse_idx_out <= idx_d;
`ifdef BURST_TX_GAP_EN
      gap_q         <= gap_d;
`endif
    end
  end

endmodule

// File: tb/tb_burst_tx.sv
// tb_burst_tx: vector table, directed multi-cycle sequences and random stimulus for burst_tx,
// checked against a tick-counting reference model of the burst.
module tb_burst_tx;

  localparam int P   = 4;
  localparam int GAP = 3;
`ifdef BURST_TX_GAP_EN
  localparam bit GAP_ON = (GAP != 0);
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in, tick_in, start_in, abort_in;
  logic       sig_out, busy_out, done_out;
  logic [1:0] pulse_idx_out;

  burst_tx #(.PULSES_PER_BURST(P), .GAP_TICKS(GAP)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .tick_in(tick_in), .start_in(start_in),
    .abort_in(abort_in), .sig_out(sig_out), .busy_out(busy_out), .done_out(done_out),
    .pulse_idx_out(pulse_idx_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int rises, dones, tcyc;
  bit check_model;

  // Reference model: phase 0 idle, 1 burst (m_k ticks taken since arming), 2 guard gap.
  int m_phase, m_k, m_g;
  bit m_done;

  task automatic model_update(input logic r, input logic s, input logic t, input logic a);
    m_done = 1'b0;
    if (!r) begin
      m_phase = 0; m_k = 0; m_g = 0;
    end else if (m_phase != 0 && a) begin
      m_phase = 0; m_k = 0; m_g = 0;
    end else if (m_phase == 0) begin
      if (s && !a) begin m_phase = 1; m_k = 0; end
    end else if (m_phase == 1) begin
      if (t) begin
        m_k++;
        if (m_k == 2 * P + 1) begin
          m_done = 1'b1;
          m_k = 0;
          if (GAP_ON) begin m_phase = 2; m_g = GAP; end
          else m_phase = 0;
        end
      end
    end else if (t) begin
      m_g--;
      if (m_g == 0) m_phase = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int e_idx;
    e_idx = (m_phase == 1 && m_k > 0) ? (m_k - 1) / 2 : 0;
    chk("model_sig", 32'(sig_out), (m_phase == 1 && (m_k % 2) == 1) ? 32'd1 : 32'd0);
    chk("model_busy", 32'(busy_out), (m_phase != 0) ? 32'd1 : 32'd0);
    chk("model_done", 32'(done_out), 32'(m_done));
    chk("model_idx", 32'(pulse_idx_out), 32'(e_idx));
  endtask

  task automatic step(input logic r, input logic s, input logic t, input logic a);
    logic prev_sig;
    prev_sig = sig_out;
    rst_in = r; start_in = s; tick_in = t; abort_in = a;
    @(posedge clk_in);
    #1;
    model_update(r, s, t, a);
    if (sig_out === 1'b1 && prev_sig === 1'b0) rises++;
    if (done_out === 1'b1) dones++;
    if (check_model) check_outputs();
  endtask

  // Timebase modelled on evt_counter with MAX_COUNT=5: one tick every fifth clock.
  task automatic tstep(input logic s, input logic a);
    step(1'b1, s, (tcyc % 5) == 4, a);
    tcyc++;
  endtask

  typedef struct {
    logic r, s, t, a;
    logic e_sig, e_busy, e_done;
    logic [1:0] e_idx;
  } vec_t;

  vec_t vec[15];

  initial begin
    bit started, aborted, seen;
    int first;

    rst_in = 1'b0; start_in = 1'b0; tick_in = 1'b0; abort_in = 1'b0;
    check_model = 1'b0;
    m_phase = 0; m_k = 0; m_g = 0; m_done = 1'b0;

    // Reset held with start and tick active must keep everything low.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("rst_sig", 32'(sig_out), 0);
      chk("rst_busy", 32'(busy_out), 0);
      chk("rst_done", 32'(done_out), 0);
      chk("rst_idx", 32'(pulse_idx_out), 0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rel_busy", 32'(busy_out), 0);

    // {rst, start, tick, abort, sig, busy, done, idx}
    vec[0]  = '{1, 1, 1, 0, 0, 1, 0, 2'd0};
    vec[1]  = '{1, 0, 0, 0, 0, 1, 0, 2'd0};
    vec[2]  = '{1, 0, 1, 0, 1, 1, 0, 2'd0};
    vec[3]  = '{1, 1, 0, 0, 1, 1, 0, 2'd0};
    vec[4]  = '{1, 0, 1, 0, 0, 1, 0, 2'd0};
    vec[5]  = '{1, 0, 1, 0, 1, 1, 0, 2'd1};
    vec[6]  = '{1, 0, 1, 1, 0, 0, 0, 2'd0};
    vec[7]  = '{1, 1, 0, 1, 0, 0, 0, 2'd0};
    vec[8]  = '{1, 0, 1, 0, 0, 0, 0, 2'd0};
    vec[9]  = '{1, 1, 0, 0, 0, 1, 0, 2'd0};
    vec[10] = '{1, 0, 0, 1, 0, 0, 0, 2'd0};
    vec[11] = '{1, 1, 0, 0, 0, 1, 0, 2'd0};
    vec[12] = '{1, 0, 1, 0, 1, 1, 0, 2'd0};
    vec[13] = '{0, 0, 1, 0, 0, 0, 0, 2'd0};
    vec[14] = '{1, 0, 0, 0, 0, 0, 0, 2'd0};
    for (int i = 0; i < 15; i++) begin
      step(vec[i].r, vec[i].s, vec[i].t, vec[i].a);
      chk($sformatf("vec%0d_sig", i), 32'(sig_out), 32'(vec[i].e_sig));
      chk($sformatf("vec%0d_busy", i), 32'(busy_out), 32'(vec[i].e_busy));
      chk($sformatf("vec%0d_done", i), 32'(done_out), 32'(vec[i].e_done));
      chk($sformatf("vec%0d_idx", i), 32'(pulse_idx_out), 32'(vec[i].e_idx));
    end

    check_model = 1'b1;

    // Nominal burst: four carrier periods, one done pulse, idle again by the end.
    tcyc = 0; rises = 0; dones = 0;
    tstep(1'b1, 1'b0);
    for (int i = 0; i < 60; i++) tstep(1'b0, 1'b0);
    chk("nom_rises", 32'(rises), 4);
    chk("nom_dones", 32'(dones), 1);
    chk("nom_busy_end", 32'(busy_out), 0);

    // A start issued mid-burst is neither queued nor restarts the burst.
    tcyc = 0; rises = 0; dones = 0; started = 1'b0;
    tstep(1'b1, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (!started && m_phase == 1 && m_k == 3) begin
        started = 1'b1;
        tstep(1'b1, 1'b0);
      end else tstep(1'b0, 1'b0);
    end
    chk("busy_start_rises", 32'(rises), 4);
    chk("busy_start_dones", 32'(dones), 1);

    // Abort together with a tick during the second high phase.
    tcyc = 0; rises = 0; dones = 0; aborted = 1'b0;
    tstep(1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (!aborted && m_phase == 1 && m_k == 3 && (tcyc % 5) == 4) begin
        aborted = 1'b1;
        tstep(1'b0, 1'b1);
        chk("abort_sig", 32'(sig_out), 0);
        chk("abort_busy", 32'(busy_out), 0);
        chk("abort_idx", 32'(pulse_idx_out), 0);
      end else tstep(1'b0, 1'b0);
    end
    chk("abort_taken", 32'(aborted), 1);
    chk("abort_dones", 32'(dones), 0);

    // Abort on the final low tick suppresses done.
    tcyc = 0; dones = 0; aborted = 1'b0;
    tstep(1'b1, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (!aborted && m_phase == 1 && m_k == 2 * P && (tcyc % 5) == 4) begin
        aborted = 1'b1;
        tstep(1'b0, 1'b1);
        chk("abort_final_done", 32'(done_out), 0);
      end else tstep(1'b0, 1'b0);
    end
    chk("abort_final_dones", 32'(dones), 0);

    // Start coinciding with a tick: the carrier rises only on the next tick.
    tcyc = 4; first = -1;
    tstep(1'b1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      tstep(1'b0, 1'b0);
      if (sig_out === 1'b1 && first < 0) first = c;
    end
    chk("start_tick_rise", 32'(first), 5);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Back-to-back start right after done.
    tcyc = 0; seen = 1'b0;
    tstep(1'b1, 1'b0);
    for (int i = 0; i < 60 && !seen; i++) begin
      tstep(1'b0, 1'b0);
      if (done_out === 1'b1) seen = 1'b1;
    end
    chk("b2b_done_seen", 32'(seen), 1);
    chk("b2b_busy_at_done", 32'(busy_out), GAP_ON ? 32'd1 : 32'd0);
    tstep(1'b1, 1'b0);
    chk("b2b_busy_next", 32'(busy_out), 1);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 300) != 0, ($urandom % 8) == 0, ($urandom % 3) == 0,
           ($urandom % 60) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
